instruction_sequencer: RTL and testbench
========================================

// Module: instruction_sequencer
// PURPOSE
//  Parametrised successor to the 24-bit command decoder. Fetches command words from instruction
//  memory at instructionPointer and resolves address-flagged operands through a register-file
//  read port. Issues add/sub/invert/mov to the execution unit over a valid/ready handshake and
//  executes jfe/jfl/jfg internally from latched compare flags. Sits between instruction memory,
//  register file and ALU as the CPU control path.
// PARAMETERS
//  DATA_W      8   operand/value width; command word CMD_W = OPC_W + 2*(DATA_W+1) (default 24)
//  OPC_W       6   opcode field width
//  IP_W        8   instruction pointer width
//  RESET_IP    0   instructionPointer value after reset
//  TRAP_VECTOR 255 jump target on illegal opcode (used only with ILLEGAL_TRAP_EN)
// PORTS
//  clock              in   1        single clock, all logic on posedge
//  reset              in   1        synchronous, active-high
//  instructionPointer out  IP_W     current IP; drives instruction memory address
//  instrReq           out  1        fetch request
//  commandIn          in   CMD_W    {opcode, f1, v1[DATA_W], f2, v2[DATA_W]}; fN=1 -> vN is an address
//  instrValid         in   1        commandIn valid; sampled only while instrReq=1
//  regReadReq         out  1        register read request
//  regReadAddr        out  DATA_W   register address
//  regReadData        in   DATA_W   read data
//  regReadValid       in   1        read data valid; sampled only while regReadReq=1
//  opValid            out  1        operation offered to execution unit
//  opReady            in   1        execution unit accepts (transfer on opValid&&opReady)
//  opcodeOut          out  OPC_W    opcode
//  value1Out          out  DATA_W   resolved operand 1
//  value2Out          out  DATA_W   resolved operand 2
//  value1Addy         out  DATA_W   raw v1 field (destination address)
//  opDone             in   1        operation complete
//  flagsIn            in   3        {gt,eq,lt}, sampled with opDone
//  halted             out  1        sequencer stopped
//  trap               out  1        illegal-opcode pulse (ILLEGAL_TRAP_EN only, else tied 0)
// BEHAVIOUR
//  Opcodes: 0 halt, 1 add, 2 sub, 3 invert, 4 mov, 5 jfe, 6 jfl, 7 jfg, others illegal.
//  States: FETCH -> DECODE -> [RD1] -> [RD2] -> EXEC -> WAIT -> FETCH; jumps: ... -> JUMP -> FETCH; HALT.
//  - FETCH: instrReq=1; on instrValid latch commandIn -> DECODE.
//  - DECODE (1 cycle): opcode 0 -> HALT; illegal -> HALT (or trap, see CONFIGURATION);
//    else f1 -> RD1, else f2 -> RD2, else EXEC/JUMP.
//  - RD1/RD2: regReadReq=1, regReadAddr=v1/v2 field; on regReadValid latch operand.
//    RD1 -> RD2 if f2, else EXEC/JUMP. Operands are fetched for every opcode, invert included.
//  - EXEC: opValid=1; opcodeOut/value*/value1Addy held stable until opReady. Then WAIT.
//  - WAIT: on opDone latch flagsIn into flag reg; IP<=IP+1 -> FETCH. opDone in any other state ignored.
//  - JUMP (1 cycle): taken if (jfe&eq)|(jfl&lt)|(jfg&gt) from flag reg.
//    Taken -> IP <= resolved value1 (truncated or zero-extended to IP_W); not taken -> IP+1.
//  - HALT: halted=1, sticky; all requests low until reset.
//  IP increment wraps 2^IP_W-1 -> 0. Flag reg is updated only by opDone, never by jumps.
//  Min latency, no address flags: ALU op 4 cycles (FETCH, DECODE, EXEC, WAIT, each 1 cycle); jump 3 cycles.
//  Reset (any state, mid-handshake included): state=FETCH, IP=RESET_IP, flags=000.
//    All outputs 0 except instructionPointer=RESET_IP; instrReq=1 the cycle after reset deasserts.
//  Outputs are registered; requests never drop before their valid/ready is seen.
// CONFIGURATION
//  ILLEGAL_TRAP_EN defined:
//    illegal opcode -> trap=1 for one cycle, IP <= TRAP_VECTOR, state -> FETCH; halted stays 0.
//  Not defined: illegal opcode -> HALT (halted=1, IP unchanged); trap tied 0.
// TESTING
//  1 add, no flags: cmd {1,0,0x05,0,0x03}, opReady=1, opDone next cycle
//    -> opcodeOut=1, value1Out=5, value2Out=3; IP 0->1.
//  2 address operands: cmd {2,1,0x10,1,0x11}, regfile[0x10]=9, [0x11]=4
//    -> two reads, addrs 0x10 then 0x11; value1Out=9, value2Out=4.
//  3 jump: sub sets flagsIn=010, then jfe {5,0,0x40,..} -> IP=0x40; jfl instead -> IP=prev+1.
//  4 backpressure: opReady low 5 cycles -> opValid and all op outputs stable; one transfer only.
//  5 IP=255 non-jump -> IP wraps to 0; opcode 0 -> halted=1, no further instrReq.
//  6 reset asserted in WAIT and RD1 -> next cycle IP=RESET_IP, opValid=0, regReadReq=0, flags=000.
//    Illegal opcode 0x3F: trap pulse and IP=255 with macro; halted=1 without.

Source files
------------

// File: rtl/instruction_sequencer.sv
// instruction_sequencer
//   Control path of a small CPU. Fetches a command word from instruction memory,
//   resolves address-flagged operands through a register-file read port, hands
//   add/sub/invert/mov to the execution unit over a valid/ready handshake and
//   executes the conditional jumps jfe/jfl/jfg internally from latched flags.
//
//   Command word: {opcode[OPC_W], f1, v1[DATA_W], f2, v2[DATA_W]}; fN=1 -> vN is
//   a register address instead of an immediate.
//
// Ports
//   clock, reset                 single clock, synchronous active-high reset
//   instructionPointer, instrReq instruction memory address / fetch request
//   commandIn, instrValid        fetched command word and its valid
//   regReadReq, regReadAddr      register read request / address
//   regReadData, regReadValid    register read data / valid
//   opValid, opReady             operation handshake towards execution unit
//   opcodeOut, value1Out,
//   value2Out, value1Addy        operation payload (value1Addy = raw v1 field)
//   opDone, flagsIn              completion strobe and {gt,eq,lt} result flags
//   halted                       sticky stop indication
//   trap                         one-cycle illegal-opcode pulse
//
// Build option
//   ILLEGAL_TRAP_EN : illegal opcodes pulse trap and jump to TRAP_VECTOR.
//                     When undefined, illegal opcodes halt and trap stays 0.

module instruction_sequencer #(
  parameter int DATA_W      = 8,
  parameter int OPC_W       = 6,
  parameter int IP_W        = 8,
  parameter int RESET_IP    = 0,
  parameter int TRAP_VECTOR = 255,
  localparam int CMD_W      = OPC_W + 2 * (DATA_W + 1)
) (
  input  logic              clock,
  input  logic              reset,
  output logic [IP_W-1:0]   instructionPointer,
  output logic              instrReq,
  input  logic [CMD_W-1:0]  commandIn,
  input  logic              instrValid,
  output logic              regReadReq,
  output logic [DATA_W-1:0] regReadAddr,
  input  logic [DATA_W-1:0] regReadData,
  input  logic              regReadValid,
  output logic              opValid,
  input  logic              opReady,
  output logic [OPC_W-1:0]  opcodeOut,
  output logic [DATA_W-1:0] value1Out,
  output logic [DATA_W-1:0] value2Out,
  output logic [DATA_W-1:0] value1Addy,
  input  logic              opDone,
  input  logic [2:0]        flagsIn,
  output logic              halted,
  output logic              trap
);

`ifdef ILLEGAL_TRAP_EN
  localparam bit TRAP_EN = 1'b1;
`else
  localparam bit TRAP_EN = 1'b0;
`endif

  localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(0);
  localparam logic [OPC_W-1:0] OP_JFE  = OPC_W'(5);
  localparam logic [OPC_W-1:0] OP_JFL  = OPC_W'(6);
  localparam logic [OPC_W-1:0] OP_JFG  = OPC_W'(7);
  localparam logic [IP_W-1:0]  IP_RST  = IP_W'(RESET_IP);
  localparam logic [IP_W-1:0]  IP_TRAP = IP_W'(TRAP_VECTOR);

  typedef enum logic [2:0] {
    S_FETCH, S_DECODE, S_RD1, S_RD2, S_EXEC, S_WAIT, S_JUMP, S_HALT
  } state_t;

  state_t              state_q, state_d;
  logic [IP_W-1:0]     ip_q, ip_d;
  logic [CMD_W-1:0]    cmd_q, cmd_d;
  logic [DATA_W-1:0]   val1_q, val1_d, val2_q, val2_d;
  logic [2:0]          flags_q, flags_d;  // {gt, eq, lt}
  logic                instr_req_q, instr_req_d;
  logic                reg_read_req_q, reg_read_req_d;
  logic [DATA_W-1:0]   reg_read_addr_q, reg_read_addr_d;
  logic                op_valid_q, op_valid_d;
  logic [OPC_W-1:0]    opcode_out_q, opcode_out_d;
  logic [DATA_W-1:0]   value1_out_q, value1_out_d;
  logic [DATA_W-1:0]   value2_out_q, value2_out_d;
  logic [DATA_W-1:0]   value1_addy_q, value1_addy_d;
  logic                halted_q, halted_d;
  logic                trap_q, trap_d;

  // Fields of the latched command word
  logic [OPC_W-1:0]  cmd_opc;
  logic              cmd_f1, cmd_f2;
  logic [DATA_W-1:0] cmd_v1, cmd_v2;
  logic              cmd_is_jump, jump_taken;
  state_t            operand_done_state;

  assign cmd_opc = cmd_q[CMD_W-1 -: OPC_W];
  assign cmd_f1  = cmd_q[2*DATA_W+1];
  assign cmd_v1  = cmd_q[2*DATA_W -: DATA_W];
  assign cmd_f2  = cmd_q[DATA_W];
  assign cmd_v2  = cmd_q[DATA_W-1:0];

  assign cmd_is_jump = (cmd_opc == OP_JFE) || (cmd_opc == OP_JFL) || (cmd_opc == OP_JFG);
  assign jump_taken  = ((cmd_opc == OP_JFE) && flags_q[1]) ||
                       ((cmd_opc == OP_JFL) && flags_q[0]) ||
                       ((cmd_opc == OP_JFG) && flags_q[2]);
  // Where to go once all operands are resolved
  assign operand_done_state = cmd_is_jump ? S_JUMP : S_EXEC;

  always_comb begin
    state_d         = state_q;
    ip_d            = ip_q;
    cmd_d           = cmd_q;
    val1_d          = val1_q;
    val2_d          = val2_q;
    flags_d         = flags_q;
    reg_read_addr_d = reg_read_addr_q;
    opcode_out_d    = opcode_out_q;
    value1_out_d    = value1_out_q;
    value2_out_d    = value2_out_q;
    value1_addy_d   = value1_addy_q;
    trap_d          = 1'b0;

    case (state_q)
      S_FETCH: begin
        if (instr_req_q && instrValid) begin
          cmd_d   = commandIn;
          state_d = S_DECODE;
        end
      end
      S_DECODE: begin
        // Immediates first; register reads overwrite them below.
        val1_d = cmd_v1;
        val2_d = cmd_v2;
        if (cmd_opc == OP_HALT) begin
          state_d = S_HALT;
        end else if (cmd_opc > OP_JFG) begin
          if (TRAP_EN) begin
            trap_d  = 1'b1;
            ip_d    = IP_TRAP;
            state_d = S_FETCH;
          end else begin
            state_d = S_HALT;
          end
        end else if (cmd_f1) begin
          reg_read_addr_d = cmd_v1;
          state_d         = S_RD1;
        end else if (cmd_f2) begin
          reg_read_addr_d = cmd_v2;
          state_d         = S_RD2;
        end else begin
          state_d = operand_done_state;
        end
      end
      S_RD1: begin
        if (reg_read_req_q && regReadValid) begin
          val1_d = regReadData;
          if (cmd_f2) begin
            reg_read_addr_d = cmd_v2;
            state_d         = S_RD2;
          end else begin
            state_d = operand_done_state;
          end
        end
      end
      S_RD2: begin
        if (reg_read_req_q && regReadValid) begin
          val2_d  = regReadData;
          state_d = operand_done_state;
        end
      end
      S_EXEC: begin
        if (op_valid_q && opReady) state_d = S_WAIT;
      end
      S_WAIT: begin
        if (opDone) begin
          flags_d = flagsIn;
          ip_d    = ip_q + IP_W'(1);
          state_d = S_FETCH;
        end
      end
      S_JUMP: begin
        ip_d    = jump_taken ? IP_W'(val1_q) : ip_q + IP_W'(1);
        state_d = S_FETCH;
      end
      default: state_d = S_HALT;
    endcase

    // Outputs are registered from the next state so they line up with it.
    instr_req_d    = (state_d == S_FETCH);
    reg_read_req_d = (state_d == S_RD1) || (state_d == S_RD2);
    op_valid_d     = (state_d == S_EXEC);
    halted_d       = (state_d == S_HALT);

    // Payload is captured once on entry to EXEC and held through backpressure.
    if ((state_d == S_EXEC) && (state_q != S_EXEC)) begin
      opcode_out_d  = cmd_opc;
      value1_out_d  = val1_d;
      value2_out_d  = val2_d;
      value1_addy_d = cmd_v1;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q         <= S_FETCH;
      ip_q            <= IP_RST;
      cmd_q           <= '0;
      val1_q          <= '0;
      val2_q          <= '0;
      flags_q         <= '0;
      instr_req_q     <= 1'b0;
      reg_read_req_q  <= 1'b0;
      reg_read_addr_q <= '0;
      op_valid_q      <= 1'b0;
      opcode_out_q    <= '0;
      value1_out_q    <= '0;
      value2_out_q    <= '0;
      value1_addy_q   <= '0;
      halted_q        <= 1'b0;
      trap_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      ip_q            <= ip_d;
      cmd_q           <= cmd_d;
      val1_q          <= val1_d;
      val2_q          <= val2_d;
      flags_q         <= flags_d;
      instr_req_q     <= instr_req_d;
      reg_read_req_q  <= reg_read_req_d;
      reg_read_addr_q <= reg_read_addr_d;
      op_valid_q      <= op_valid_d;
      opcode_out_q    <= opcode_out_d;
      value1_out_q    <= value1_out_d;
      value2_out_q    <= value2_out_d;
      value1_addy_q   <= value1_addy_d;
      halted_q        <= halted_d;
      trap_q          <= trap_d;
    end
  end

  assign instructionPointer = ip_q;
  assign instrReq           = instr_req_q;
  assign regReadReq         = reg_read_req_q;
  assign regReadAddr        = reg_read_addr_q;
  assign opValid            = op_valid_q;
  assign opcodeOut          = opcode_out_q;
  assign value1Out          = value1_out_q;
  assign value2Out          = value2_out_q;
  assign value1Addy         = value1_addy_q;
  assign halted             = halted_q;
  assign trap               = TRAP_EN ? trap_q : 1'b0;

endmodule

// File: tb/tb_instruction_sequencer.sv
// Directed testbench for instruction_sequencer (default parameters, 24-bit command).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_instruction_sequencer;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [7:0]  instructionPointer;
  logic        instrReq;
  logic [23:0] commandIn = '0;
  logic        instrValid = 1'b0;
  logic        regReadReq;
  logic [7:0]  regReadAddr;
  logic [7:0]  regReadData = '0;
  logic        regReadValid = 1'b0;
  logic        opValid;
  logic        opReady = 1'b0;
  logic [5:0]  opcodeOut;
  logic [7:0]  value1Out;
  logic [7:0]  value2Out;
  logic [7:0]  value1Addy;
  logic        opDone = 1'b0;
  logic [2:0]  flagsIn = '0;
  logic        halted;
  logic        trap;

  int checks = 0;
  int errors = 0;

  instruction_sequencer dut (
    .clock(clock), .reset(reset),
    .instructionPointer(instructionPointer), .instrReq(instrReq),
    .commandIn(commandIn), .instrValid(instrValid),
    .regReadReq(regReadReq), .regReadAddr(regReadAddr),
    .regReadData(regReadData), .regReadValid(regReadValid),
    .opValid(opValid), .opReady(opReady),
    .opcodeOut(opcodeOut), .value1Out(value1Out), .value2Out(value2Out),
    .value1Addy(value1Addy), .opDone(opDone), .flagsIn(flagsIn),
    .halted(halted), .trap(trap)
  );

  always #5 clock = ~clock;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
    end
  endtask

  function automatic logic [23:0] mk(input logic [5:0] opc, input logic f1, input logic [7:0] v1,
                                     input logic f2, input logic [7:0] v2);
    return {opc, f1, v1, f2, v2};
  endfunction

  function automatic logic sig_of(input int sel);
    case (sel)
      0:       return instrReq;
      1:       return regReadReq;
      default: return opValid;
    endcase
  endfunction

  // Wait (bounded) on a negedge until the selected request goes high.
  task automatic wait_high(input int sel, input string tag);
    int n = 0;
    while (!sig_of(sel) && n < 50) begin
      @(negedge clock);
      n++;
    end
    check_val(tag, sig_of(sel), 1);
  endtask

  // Present a command while instrReq is high; returns on the DECODE negedge.
  task automatic fetch(input logic [23:0] cmd, input string name);
    wait_high(0, "fetch_req");
    $display("TXN ip=%02h %s cmd=%06h", instructionPointer, name, cmd);
    commandIn  = cmd;
    instrValid = 1'b1;
    @(negedge clock);
    instrValid = 1'b0;
    check_val("req_drop", instrReq, 0);
  endtask

  // Called at a negedge with opValid high: accept, then complete with flags.
  task automatic finish_op(input logic [2:0] flags);
    opReady = 1'b1;
    @(negedge clock);
    opReady = 1'b0;
    check_val("one_transfer", opValid, 0);
    opDone  = 1'b1;
    flagsIn = flags;
    @(negedge clock);
    opDone  = 1'b0;
    flagsIn = '0;
  endtask

  task automatic do_jump(input logic [23:0] cmd, input string name, input logic [7:0] exp_ip);
    fetch(cmd, name);
    @(negedge clock);
    check_val("jump_no_op", opValid, 0);
    @(negedge clock);
    check_val({name, "_ip"}, instructionPointer, exp_ip);
    check_val({name, "_req"}, instrReq, 1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clock);
    check_val("rst_ip", instructionPointer, 0);
    check_val("rst_opvalid", opValid, 0);
    check_val("rst_regreq", regReadReq, 0);
    check_val("rst_instrreq", instrReq, 0);
    check_val("rst_halted", halted, 0);
    reset = 1'b0;
    @(negedge clock);
    check_val("rst_req_after", instrReq, 1);
  endtask

  initial begin
    int seen;
    repeat (3) @(negedge clock);
    check_val("rst_ip", instructionPointer, 0);
    check_val("rst_instrreq", instrReq, 0);
    check_val("rst_opvalid", opValid, 0);
    check_val("rst_regreq", regReadReq, 0);
    check_val("rst_halted", halted, 0);
    check_val("rst_trap", trap, 0);
    reset = 1'b0;
    @(negedge clock);
    check_val("req_after_rst", instrReq, 1);

    // 1: add with immediates, minimum latency
    fetch(mk(6'd1, 1'b0, 8'h05, 1'b0, 8'h03), "add");
    check_val("add_decode_noop", opValid, 0);
    @(negedge clock);
    check_val("add_opvalid", opValid, 1);
    check_val("add_opc", opcodeOut, 1);
    check_val("add_v1", value1Out, 8'h05);
    check_val("add_v2", value2Out, 8'h03);
    check_val("add_addy", value1Addy, 8'h05);
    finish_op(3'b000);
    check_val("add_ip", instructionPointer, 1);
    check_val("add_req", instrReq, 1);

    // 2: sub with both operands from registers, read stalls first
    fetch(mk(6'd2, 1'b1, 8'h10, 1'b1, 8'h11), "sub_addr");
    wait_high(1, "rd1_req");
    check_val("rd1_addr", regReadAddr, 8'h10);
    repeat (2) @(negedge clock);
    check_val("rd1_hold_req", regReadReq, 1);
    check_val("rd1_hold_addr", regReadAddr, 8'h10);
    regReadData = 8'd9; regReadValid = 1'b1;
    @(negedge clock);
    regReadValid = 1'b0;
    check_val("rd2_req", regReadReq, 1);
    check_val("rd2_addr", regReadAddr, 8'h11);
    regReadData = 8'd4; regReadValid = 1'b1;
    @(negedge clock);
    regReadValid = 1'b0;
    check_val("sub_opvalid", opValid, 1);
    check_val("sub_regreq_low", regReadReq, 0);
    check_val("sub_opc", opcodeOut, 2);
    check_val("sub_v1", value1Out, 9);
    check_val("sub_v2", value2Out, 4);
    check_val("sub_addy", value1Addy, 8'h10);
    finish_op(3'b010);                    // eq set
    check_val("sub_ip", instructionPointer, 2);

    // 3: jumps from the latched eq flag; jumps leave the flags alone
    do_jump(mk(6'd5, 1'b0, 8'h40, 1'b0, 8'h00), "jfe_taken", 8'h40);
    do_jump(mk(6'd6, 1'b0, 8'h80, 1'b0, 8'h00), "jfl_not", 8'h41);
    do_jump(mk(6'd5, 1'b0, 8'h20, 1'b0, 8'h00), "jfe_again", 8'h20);

    // 4: backpressure; an opDone during EXEC must be ignored
    fetch(mk(6'd4, 1'b0, 8'h77, 1'b0, 8'h12), "mov_bp");
    wait_high(2, "mov_opvalid");
    opDone = 1'b1; flagsIn = 3'b001;
    for (int i = 0; i < 5; i++) begin
      check_val("bp_valid", opValid, 1);
      check_val("bp_opc", opcodeOut, 4);
      check_val("bp_v1", value1Out, 8'h77);
      check_val("bp_v2", value2Out, 8'h12);
      check_val("bp_ip", instructionPointer, 8'h20);
      @(negedge clock);
    end
    opDone = 1'b0; flagsIn = '0;
    check_val("bp_still_valid", opValid, 1);
    finish_op(3'b100);                    // gt set
    check_val("mov_ip", instructionPointer, 8'h21);

    // opDone while fetching must not touch the flags
    opDone = 1'b1; flagsIn = 3'b010;
    @(negedge clock);
    opDone = 1'b0; flagsIn = '0;
    do_jump(mk(6'd5, 1'b0, 8'h60, 1'b0, 8'h00), "jfe_gt_not", 8'h22);
    do_jump(mk(6'd7, 1'b0, 8'hFF, 1'b0, 8'h00), "jfg_taken", 8'hFF);

    // 5: IP wrap, then invert with only operand 1 from a register
    fetch(mk(6'd1, 1'b0, 8'h01, 1'b0, 8'h01), "add_wrap");
    wait_high(2, "wrap_opvalid");
    finish_op(3'b000);
    check_val("wrap_ip", instructionPointer, 0);

    fetch(mk(6'd3, 1'b1, 8'h05, 1'b0, 8'h00), "invert_addr");
    wait_high(1, "inv_rd_req");
    check_val("inv_rd_addr", regReadAddr, 8'h05);
    regReadData = 8'hA5; regReadValid = 1'b1;
    @(negedge clock);
    regReadValid = 1'b0;
    check_val("inv_opvalid", opValid, 1);
    check_val("inv_regreq_low", regReadReq, 0);
    check_val("inv_opc", opcodeOut, 3);
    check_val("inv_v1", value1Out, 8'hA5);
    check_val("inv_v2", value2Out, 8'h00);
    finish_op(3'b010);                    // eq set before reset
    check_val("inv_ip", instructionPointer, 1);

    // 6: reset in WAIT clears flags: jfe afterwards is not taken
    fetch(mk(6'd1, 1'b0, 8'h02, 1'b0, 8'h02), "add_rst_wait");
    wait_high(2, "rw_opvalid");
    opReady = 1'b1;
    @(negedge clock);
    opReady = 1'b0;
    $display("TXN reset during WAIT");
    pulse_reset();
    do_jump(mk(6'd5, 1'b0, 8'h30, 1'b0, 8'h00), "jfe_after_rst", 8'h01);

    // reset in RD1
    fetch(mk(6'd2, 1'b1, 8'h08, 1'b0, 8'h01), "sub_rst_rd1");
    wait_high(1, "rr_req");
    $display("TXN reset during RD1");
    pulse_reset();

    // illegal opcode
    fetch(mk(6'h3F, 1'b0, 8'h00, 1'b0, 8'h00), "illegal");
    @(negedge clock);
`ifdef ILLEGAL_TRAP_EN
    check_val("ill_trap", trap, 1);
    check_val("ill_ip", instructionPointer, 8'hFF);
    check_val("ill_halted", halted, 0);
    @(negedge clock);
    check_val("ill_trap_pulse", trap, 0);
    check_val("ill_req", instrReq, 1);
`else
    check_val("ill_halted", halted, 1);
    check_val("ill_ip", instructionPointer, 0);
    check_val("ill_trap", trap, 0);
    check_val("ill_req", instrReq, 0);
`endif
    pulse_reset();

    // halt opcode: sticky, no further requests
    fetch(mk(6'd0, 1'b0, 8'h00, 1'b0, 8'h00), "halt");
    @(negedge clock);
    check_val("halt_halted", halted, 1);
    check_val("halt_ip", instructionPointer, 0);
    seen = 0;
    repeat (5) begin
      @(negedge clock);
      if (instrReq || regReadReq || opValid) seen++;
    end
    check_val("halt_no_req", seen, 0);
    check_val("halt_sticky", halted, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
